fpmul_iter: RTL and testbench

Parametrised IEEE-754-style floating-point multiplier. It replaces single-cycle combinational multiplication with an iterative radix-2 shift-add mantissa datapath. Operands and results move over valid/ready handshakes. The block adds full special-case handling, normalisation, rounding and exception flags. It sits between the operand register file and the result writeback in the FP datapath.

---
 rtl/fpmul_pkg.sv | 49 ++++
 rtl/fpmul_iter_mant.sv | 42 ++++
 rtl/fpmul_iter.sv | 211 +++++++++++++++++++++
 tb/tb_fpmul_iter.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/fpmul_pkg.sv
// Shared types and constants for the iterative floating-point multiplier.
// Holds the FSM state enum, the operand class enum, flag indices and IEEE pattern helpers.
package fpmul_pkg;

    typedef enum logic [2:0] {
        IDLE,
        UNPACK,
        MULT,
        NORM,
        ROUND,
        DONE
    } state_e;

    typedef enum logic [1:0] {
        CLS_ZERO,
        CLS_INF,
        CLS_NAN,
        CLS_NORM
    } cls_e;

    localparam int FLG_INV = 3;
    localparam int FLG_OVF = 2;
    localparam int FLG_UNF = 1;
    localparam int FLG_INX = 0;

    // Magnitude patterns (sign bit excluded); callers cast to their word width.
    function automatic logic [63:0] inf_mag(input int exp_w, input int man_w);
        logic [63:0] w;
        w = '0;
        for (int i = 0; i < exp_w; i++) w[man_w + i] = 1'b1;
        return w;
    endfunction

    function automatic logic [63:0] qnan_mag(input int exp_w, input int man_w);
        logic [63:0] w;
        w = inf_mag(exp_w, man_w);
        w[man_w - 1] = 1'b1;
        return w;
    endfunction

    function automatic logic [63:0] max_mag(input int exp_w, input int man_w);
        logic [63:0] w;
        w = '0;
        for (int i = 0; i < man_w; i++) w[i] = 1'b1;
        for (int i = 1; i < exp_w; i++) w[man_w + i] = 1'b1;
        return w;
    endfunction

endpackage

// File: rtl/fpmul_iter_mant.sv
// Radix-2 shift-add significand multiplier: one partial product per cycle.
// The multiplier rides in the low half of prod and is shifted out as the product shifts in.
module mant_mult_iter #(
    parameter int SW = 24
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [SW-1:0]   mcand,
    input  logic [SW-1:0]   mplier,
    output logic            last,
    output logic [2*SW-1:0] prod
);
    localparam int CW = $clog2(SW);

    logic          busy;
    logic [CW-1:0] cnt;
    logic [SW-1:0] mcand_q;
    logic [SW:0]   sum;

    assign last = busy && (cnt == CW'(SW - 1));
    assign sum  = {1'b0, prod[2*SW-1:SW]} + (prod[0] ? {1'b0, mcand_q} : {(SW+1){1'b0}});

    always_ff @(posedge clk) begin
        if (reset) begin
            busy    <= 1'b0;
            cnt     <= '0;
            mcand_q <= '0;
            prod    <= '0;
        end else if (start) begin
            busy    <= 1'b1;
            cnt     <= '0;
            mcand_q <= mcand;
            prod    <= {{SW{1'b0}}, mplier};
        end else if (busy) begin
            prod <= {sum, prod[SW-1:1]};
            cnt  <= cnt + 1'b1;
            if (last) busy <= 1'b0;
        end
    end

endmodule

// File: rtl/fpmul_iter.sv
// Iterative IEEE-754-style multiplier with valid/ready operand and result handshakes.
// Define FPMUL_RNE_EN for round-to-nearest-even; otherwise results are truncated toward zero.
module fpmul_iter
    import fpmul_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int W     = EXP_W + MAN_W + 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] data_a,
    input  logic [W-1:0] data_b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] data_r,
    output logic [3:0]   flags,
    output state_e       dbg_state
);
    // Handshake: a transfer happens on a rising edge where valid && ready are both high;
    // a producer holds valid and data steady until that edge.
    localparam int SW  = MAN_W + 1;
    localparam int PW  = 2 * SW;
    localparam int EW2 = EXP_W + 2;

    localparam logic [EW2-1:0] BIAS     = EW2'((1 << (EXP_W - 1)) - 1);
    localparam logic [EW2-1:0] EXP_MAX  = EW2'((1 << EXP_W) - 1);
    localparam logic [EW2-1:0] EXP_ZERO = '0;
    localparam logic [W-2:0]   INF_MAG  = (W-1)'(inf_mag(EXP_W, MAN_W));
    localparam logic [W-2:0]   MAX_MAG  = (W-1)'(max_mag(EXP_W, MAN_W));
    localparam logic [W-1:0]   QNAN     = {1'b0, (W-1)'(qnan_mag(EXP_W, MAN_W))};

    state_e             state;
    logic [W-1:0]       a_q, b_q;
    cls_e               cls_a, cls_b, cls_a_c, cls_b_c;
    logic               unpacked;
    logic               sign_q;
    logic [EW2-1:0]     exp_q;
    logic [MAN_W-1:0]   frac_q;
    logic               g_q, r_q, s_q;
    logic               sgn;

    logic               mul_start, mul_last;
    logic [PW-1:0]      prod;

    logic               sp_hit;
    logic [W-1:0]       sp_word;
    logic [3:0]         sp_flags;

    logic [PW-2:0]      prod_sh;
    logic [EW2-1:0]     exp_norm;

    logic               rnd_inc;
    logic [MAN_W:0]     frac_inc;
    logic [EW2-1:0]     exp_rnd;
    logic [W-1:0]       rnd_word;
    logic [3:0]         rnd_flags;

    function automatic cls_e classify(input logic [W-2:0] x);
        if (x[W-2 -: EXP_W] == '0) return CLS_ZERO;
        if (&x[W-2 -: EXP_W]) return (x[MAN_W-1:0] == '0) ? CLS_INF : CLS_NAN;
        return CLS_NORM;
    endfunction

    assign dbg_state = state;
    assign sgn       = a_q[W-1] ^ b_q[W-1];
    assign cls_a_c   = classify(a_q[W-2:0]);
    assign cls_b_c   = classify(b_q[W-2:0]);
    // Start in the first UNPACK cycle so the array runs while the dispatch cycle completes.
    assign mul_start = (state == UNPACK) && !unpacked &&
                       (cls_a_c == CLS_NORM) && (cls_b_c == CLS_NORM);

    mant_mult_iter #(.SW(SW)) u_mant (
        .clk    (clk),
        .reset  (reset),
        .start  (mul_start),
        .mcand  ({1'b1, a_q[MAN_W-1:0]}),
        .mplier ({1'b1, b_q[MAN_W-1:0]}),
        .last   (mul_last),
        .prod   (prod)
    );

    always_comb begin
        sp_hit   = 1'b1;
        sp_word  = '0;
        sp_flags = '0;
        if (cls_a == CLS_NAN || cls_b == CLS_NAN ||
            (cls_a == CLS_ZERO && cls_b == CLS_INF) ||
            (cls_a == CLS_INF && cls_b == CLS_ZERO)) begin
            sp_word           = QNAN;
            sp_flags[FLG_INV] = 1'b1;
        end else if (cls_a == CLS_INF || cls_b == CLS_INF) begin
            sp_word = {sgn, INF_MAG};
        end else if (cls_a == CLS_ZERO || cls_b == CLS_ZERO) begin
            sp_word = {sgn, {(W-1){1'b0}}};
        end else begin
            sp_hit = 1'b0;
        end
    end

    // Significand product lies in [1,4): drop the leading one from whichever window holds it.
    always_comb begin
        prod_sh  = prod[PW-1] ? prod[PW-2:0] : {prod[PW-3:0], 1'b0};
        exp_norm = {2'b00, a_q[W-2 -: EXP_W]} + {2'b00, b_q[W-2 -: EXP_W]} - BIAS +
                   {{(EW2-1){1'b0}}, prod[PW-1]};
    end

    always_comb begin
`ifdef FPMUL_RNE_EN
        rnd_inc = g_q & (r_q | s_q | frac_q[0]);
`else
        rnd_inc = 1'b0;
`endif
        frac_inc  = {1'b0, frac_q} + {{MAN_W{1'b0}}, rnd_inc};
        // A carry-out leaves the fraction at zero, so renormalising only bumps the exponent.
        exp_rnd   = exp_q + {{(EW2-1){1'b0}}, frac_inc[MAN_W]};
        rnd_flags = '0;
        if ($signed(exp_rnd) >= $signed(EXP_MAX)) begin
            rnd_flags[FLG_OVF] = 1'b1;
            rnd_flags[FLG_INX] = 1'b1;
`ifdef FPMUL_RNE_EN
            rnd_word = {sign_q, INF_MAG};
`else
            rnd_word = {sign_q, MAX_MAG};
`endif
        end else if ($signed(exp_rnd) <= $signed(EXP_ZERO)) begin
            rnd_flags[FLG_UNF] = 1'b1;
            rnd_flags[FLG_INX] = 1'b1;
            rnd_word = {sign_q, {(W-1){1'b0}}};
        end else begin
            rnd_flags[FLG_INX] = g_q | r_q | s_q;
            rnd_word = {sign_q, exp_rnd[EXP_W-1:0], frac_inc[MAN_W-1:0]};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            data_r    <= '0;
            flags     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            cls_a     <= CLS_ZERO;
            cls_b     <= CLS_ZERO;
            unpacked  <= 1'b0;
            sign_q    <= 1'b0;
            exp_q     <= '0;
            frac_q    <= '0;
            g_q       <= 1'b0;
            r_q       <= 1'b0;
            s_q       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        a_q      <= data_a;
                        b_q      <= data_b;
                        in_ready <= 1'b0;
                        unpacked <= 1'b0;
                        state    <= UNPACK;
                    end
                end
                UNPACK: begin
                    if (!unpacked) begin
                        cls_a    <= cls_a_c;
                        cls_b    <= cls_b_c;
                        unpacked <= 1'b1;
                    end else if (sp_hit) begin
                        data_r    <= sp_word;
                        flags     <= sp_flags;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        sign_q <= sgn;
                        state  <= MULT;
                    end
                end
                MULT: begin
                    if (mul_last) state <= NORM;
                end
                NORM: begin
                    exp_q  <= exp_norm;
                    frac_q <= prod_sh[PW-2 -: MAN_W];
                    g_q    <= prod_sh[SW-1];
                    r_q    <= prod_sh[SW-2];
                    s_q    <= |prod_sh[SW-3:0];
                    state  <= ROUND;
                end
                ROUND: begin
                    data_r    <= rnd_word;
                    flags     <= rnd_flags;
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fpmul_iter.sv
// Directed bench for fpmul_iter: scoreboard of expected {data_r, flags} per accepted operation.
module tb_fpmul_iter;
    import fpmul_pkg::*;

    localparam int EXP_W = 8;
    localparam int MAN_W = 23;
    localparam int W     = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] data_a;
    logic [W-1:0] data_b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] data_r;
    logic [3:0]   flags;
    state_e       dbg_state;

    int errors = 0;
    int checks = 0;
    logic [W+3:0] exp_q[$];

    fpmul_iter #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_a    (data_a),
        .data_b    (data_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .data_r    (data_r),
        .flags     (flags),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed=no finish expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic push,
                        input logic [W-1:0] er, input logic [3:0] ef);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("accept_ready", 64'(in_ready), 64'(1));
        data_a   = a;
        data_b   = b;
        in_valid = 1'b1;
        if (push) exp_q.push_back({er, ef});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic recv(input string tag, input int exp_lat, input int hold);
        int lat;
        logic [W+3:0] e;
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        check({tag, "_sb_depth"}, 64'(exp_q.size()), 64'(1));
        e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        check({tag, "_data"}, 64'(data_r), 64'(e[W+3:4]));
        check({tag, "_flags"}, 64'(flags), 64'(e[3:0]));
        for (int i = 0; i < hold; i++) begin
            data_a   = $urandom;
            data_b   = $urandom;
            in_valid = 1'b1;
            @(posedge clk);
            #1;
            check({tag, "_hold_data"}, 64'(data_r), 64'(e[W+3:4]));
            check({tag, "_hold_flags"}, 64'(flags), 64'(e[3:0]));
            check({tag, "_hold_in_ready"}, 64'(in_ready), 64'(0));
            check({tag, "_hold_valid"}, 64'(out_valid), 64'(1));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, "_hs_valid"}, 64'(out_valid), 64'(0));
        check({tag, "_hs_in_ready"}, 64'(in_ready), 64'(1));
    endtask

    initial begin
        logic [W-1:0] x;
        logic         s1;
        int           n;

        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; data_a = '0; data_b = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_state", 64'(dbg_state), 64'(IDLE));
        check("rst_in_ready", 64'(in_ready), 64'(1));
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_data_r", 64'(data_r), 64'(0));
        check("rst_flags", 64'(flags), 64'(0));
        reset = 1'b0;

        send(32'h40000000, 32'h40400000, 1'b1, 32'h40C00000, 4'h0);
        recv("mul_2x3", 27, 0);

`ifdef FPMUL_RNE_EN
        send(32'h41480000, 32'hC0A66666, 1'b1, 32'hC2820000, 4'h1);
`else
        send(32'h41480000, 32'hC0A66666, 1'b1, 32'hC281FFFF, 4'h1);
`endif
        recv("mul_12p5", 27, 0);

        send(32'h3FC00000, 32'h3FC00000, 1'b1, 32'h40100000, 4'h0);
        recv("mul_1p5sq", 27, 0);

        send(32'h3F800001, 32'h3F800001, 1'b1, 32'h3F800002, 4'h1);
        recv("mul_sticky", 27, 0);

        send(32'h00000000, 32'h7F800000, 1'b1, 32'h7FC00000, 4'h8);
        recv("zero_x_inf", 2, 0);

        send(32'hFF800000, 32'h40000000, 1'b1, 32'hFF800000, 4'h0);
        recv("ninf_x_2", 2, 0);

`ifdef FPMUL_RNE_EN
        send(32'h7F000000, 32'h40000000, 1'b1, 32'h7F800000, 4'h5);
`else
        send(32'h7F000000, 32'h40000000, 1'b1, 32'h7F7FFFFF, 4'h5);
`endif
        recv("overflow", 27, 0);

        send(32'h00800000, 32'h3F000000, 1'b1, 32'h00000000, 4'h3);
        recv("underflow", 27, 0);

        for (int i = 0; i < 4; i++) begin
            x  = {1'($urandom_range(0, 1)), 8'($urandom_range(1, 254)), 23'($urandom)};
            s1 = 1'($urandom_range(0, 1));
            send({s1, 31'h3F800000}, x, 1'b1, {s1 ^ x[W-1], x[W-2:0]}, 4'h0);
            recv("mul_one", 27, 0);
        end

        for (int i = 0; i < 2; i++) begin
            x  = {1'($urandom_range(0, 1)), 8'($urandom_range(1, 254)), 23'($urandom)};
            s1 = 1'($urandom_range(0, 1));
            send({s1, 31'h0}, x, 1'b1, {s1 ^ x[W-1], 31'h0}, 4'h0);
            recv("zero_x_fin", 2, 0);
            send({s1, 8'hFF, 23'($urandom_range(1, 8388607))}, x, 1'b1, 32'h7FC00000, 4'h8);
            recv("nan_in", 2, 0);
        end

        send(32'h40000000, 32'h40400000, 1'b1, 32'h40C00000, 4'h0);
        recv("backpressure", 27, 10);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("bp_no_extra", 64'(out_valid), 64'(0));
        end

        send(32'h40000000, 32'h40400000, 1'b0, 32'h0, 4'h0);
        n = 0;
        while (dbg_state != MULT && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("reach_mult", 64'(dbg_state), 64'(MULT));
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_out_valid", 64'(out_valid), 64'(0));
        check("midrst_in_ready", 64'(in_ready), 64'(1));
        check("midrst_state", 64'(dbg_state), 64'(IDLE));
        reset = 1'b0;

        send(32'h40000000, 32'h40400000, 1'b1, 32'h40C00000, 4'h0);
        recv("after_rst", 27, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
